// File: rtl/mem_wb_skid.sv
// MEM/WB stage with a two-entry skid buffer and registered write-back data select.
// Latency is one cycle. InReady drops only when both entries are held, so a one-cycle OutReady stall costs no bubble.
module mem_wb_skid #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int MTR_W  = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] ALUResultIn,
  input  logic [DATA_W-1:0] ReadDataIn,
  input  logic [DATA_W-1:0] PCResultIn,
  input  logic [MTR_W-1:0]  MemtoRegIn,
  input  logic              RegWriteIn,
  input  logic [REG_W-1:0]  WriteRegIn,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] ALUResultOut,
  output logic [DATA_W-1:0] ReadDataOut,
  output logic [DATA_W-1:0] PCResultOut,
  output logic [MTR_W-1:0]  MemtoRegOut,
  output logic              RegWriteOut,
  output logic [REG_W-1:0]  WriteRegOut,
  output logic [DATA_W-1:0] WriteDataOut,
  output logic              WbEnOut,
  output logic [1:0]        CountOut
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} count_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] pc;
    logic [MTR_W-1:0]  mtr;
    logic              regwrite;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  count_t count;
  entry_t head;
  entry_t skid;
  entry_t in_e;
  logic   accept;
  logic   fire;

  // Write data is resolved at load time so it travels with the entry through the skid slot.
  always_comb begin
    in_e          = '0;
    in_e.alu      = ALUResultIn;
    in_e.rdata    = ReadDataIn;
    in_e.pc       = PCResultIn;
    in_e.mtr      = MemtoRegIn;
    in_e.regwrite = RegWriteIn;
    in_e.wreg     = WriteRegIn;
    case (MemtoRegIn[1:0])
      2'b00:   in_e.wdata = ALUResultIn;
      2'b01:   in_e.wdata = ReadDataIn;
      2'b10:   in_e.wdata = PCResultIn;
      default: in_e.wdata = '0;
    endcase
  end

  assign InReady = (count != FULL);
  assign OutValid = (count != EMPTY);
  assign accept = InValid & InReady & ~Flush;
  assign fire = OutValid & OutReady;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (Flush) begin
      count         <= EMPTY;
      head.regwrite <= 1'b0;
    end else begin
      case (count)
        EMPTY: begin
          if (accept) begin
            head  <= in_e;
            count <= ONE;
          end
        end
        ONE: begin
          if (accept && fire) begin
            head <= in_e;
          end else if (accept) begin
            skid  <= in_e;
            count <= FULL;
          end else if (fire) begin
            head.regwrite <= 1'b0;
            count         <= EMPTY;
          end
        end
        FULL: begin
          if (fire) begin
            head  <= skid;
            count <= ONE;
          end
        end
        default: begin
          head.regwrite <= 1'b0;
          count         <= EMPTY;
        end
      endcase
    end
  end

  assign ALUResultOut = head.alu;
  assign ReadDataOut  = head.rdata;
  assign PCResultOut  = head.pc;
  assign MemtoRegOut  = head.mtr;
  assign RegWriteOut  = head.regwrite;
  assign WriteRegOut  = head.wreg;
  assign WriteDataOut = head.wdata;
  assign CountOut     = count;
  assign WbEnOut      = fire & head.regwrite & (head.wreg != '0);

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed and random stimulus for mem_wb_skid against a bounded-queue reference model.
module tb_mem_wb_skid;

  logic        Clk = 1'b0;
  logic        Reset, Flush, InValid, InReady, OutValid, OutReady;
  logic [31:0] ALUResultIn, ReadDataIn, PCResultIn;
  logic [1:0]  MemtoRegIn;
  logic        RegWriteIn;
  logic [4:0]  WriteRegIn;
  logic [31:0] ALUResultOut, ReadDataOut, PCResultOut, WriteDataOut;
  logic [1:0]  MemtoRegOut, CountOut;
  logic        RegWriteOut, WbEnOut;
  logic [4:0]  WriteRegOut;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] rd;
    logic [31:0] pc;
    logic [1:0]  mtr;
    logic        rw;
    logic [4:0]  wr;
  } ent_t;

  ent_t q[$];

  mem_wb_skid dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .ALUResultIn(ALUResultIn), .ReadDataIn(ReadDataIn), .PCResultIn(PCResultIn),
    .MemtoRegIn(MemtoRegIn), .RegWriteIn(RegWriteIn), .WriteRegIn(WriteRegIn),
    .OutValid(OutValid), .OutReady(OutReady),
    .ALUResultOut(ALUResultOut), .ReadDataOut(ReadDataOut), .PCResultOut(PCResultOut),
    .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut), .WriteRegOut(WriteRegOut),
    .WriteDataOut(WriteDataOut), .WbEnOut(WbEnOut), .CountOut(CountOut)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wsel(input ent_t e);
    case (e.mtr)
      2'd0:    return e.alu;
      2'd1:    return e.rd;
      2'd2:    return e.pc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_outputs();
    chk("OutValid", 64'(OutValid), 64'(q.size() != 0));
    chk("CountOut", 64'(CountOut), 64'(q.size()));
    chk("InReady", 64'(InReady), 64'(q.size() < 2));
    if (q.size() != 0) begin
      chk("ALUResultOut", 64'(ALUResultOut), 64'(q[0].alu));
      chk("ReadDataOut", 64'(ReadDataOut), 64'(q[0].rd));
      chk("PCResultOut", 64'(PCResultOut), 64'(q[0].pc));
      chk("MemtoRegOut", 64'(MemtoRegOut), 64'(q[0].mtr));
      chk("RegWriteOut", 64'(RegWriteOut), 64'(q[0].rw));
      chk("WriteRegOut", 64'(WriteRegOut), 64'(q[0].wr));
      chk("WriteDataOut", 64'(WriteDataOut), 64'(wsel(q[0])));
      chk("WbEnOut", 64'(WbEnOut), 64'(OutReady && q[0].rw && q[0].wr != 5'd0));
    end else begin
      chk("RegWriteOut_empty", 64'(RegWriteOut), 64'd0);
      chk("WbEnOut_empty", 64'(WbEnOut), 64'd0);
    end
  endtask

  // Inputs are stable from 1 time unit after the rising edge until the next rising edge.
  task automatic tick();
    ent_t e;
    bit acc, fir;
    @(negedge Clk);
    check_outputs();
    acc = InValid && (q.size() < 2) && !Flush && !Reset;
    fir = (q.size() != 0) && OutReady && !Reset;
    e = '{ALUResultIn, ReadDataIn, PCResultIn, MemtoRegIn, RegWriteIn, WriteRegIn};
    @(posedge Clk);
    if (Reset || Flush) q.delete();
    else begin
      if (fir) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [31:0] pc, input logic [1:0] mtr, input logic rw,
                       input logic [4:0] wr);
    InValid = v; ALUResultIn = alu; ReadDataIn = rd; PCResultIn = pc;
    MemtoRegIn = mtr; RegWriteIn = rw; WriteRegIn = wr;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_OutValid"}, 64'(OutValid), 64'd0);
    chk({tag, "_CountOut"}, 64'(CountOut), 64'd0);
    chk({tag, "_InReady"}, 64'(InReady), 64'd1);
    chk({tag, "_RegWriteOut"}, 64'(RegWriteOut), 64'd0);
    chk({tag, "_ALUResultOut"}, 64'(ALUResultOut), 64'd0);
    chk({tag, "_ReadDataOut"}, 64'(ReadDataOut), 64'd0);
    chk({tag, "_PCResultOut"}, 64'(PCResultOut), 64'd0);
    chk({tag, "_WriteRegOut"}, 64'(WriteRegOut), 64'd0);
    chk({tag, "_MemtoRegOut"}, 64'(MemtoRegOut), 64'd0);
    chk({tag, "_WriteDataOut"}, 64'(WriteDataOut), 64'd0);
  endtask

  initial begin
    bit held;
    Reset = 1'b1; Flush = 1'b0; OutReady = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0);
    #2;
    check_zero("reset");
    tick();
    Reset = 1'b0;

    // Streaming: eight back-to-back entries with OutReady held high.
    OutReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h10 + 32'(i), 32'h0, 32'h0, 2'd0, 1'b1, 5'(i + 1));
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0);
    tick();
    tick();

    // Stall/skid: A, B, C with OutReady low for two cycles once A is at the head.
    drive(1'b1, 32'hA, 32'h0, 32'h0, 2'd0, 1'b1, 5'd10);
    tick();
    OutReady = 1'b0;
    drive(1'b1, 32'hB, 32'h0, 32'h0, 2'd0, 1'b1, 5'd11);
    tick();
    drive(1'b1, 32'hC, 32'h0, 32'h0, 2'd0, 1'b1, 5'd12);
    tick();
    chk("skid_InReady_low", 64'(InReady), 64'd0);
    OutReady = 1'b1;
    tick();
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0);
    tick();
    tick();

    // Write-data select for every MemtoReg value.
    for (int m = 0; m < 4; m++) begin
      drive(1'b1, 32'h11111111, 32'h22222222, 32'h00400008, 2'(m), 1'b1, 5'd3);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0);
    tick();

    // Register-zero write never enables the register file.
    drive(1'b1, 32'h55, 32'h0, 32'h0, 2'd0, 1'b1, 5'd0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0);
    chk("r0_OutValid", 64'(OutValid), 64'd1);
    chk("r0_WbEnOut", 64'(WbEnOut), 64'd0);
    tick();

    // Flush while FULL, with a new entry offered in the same cycle.
    OutReady = 1'b0;
    drive(1'b1, 32'h71, 32'h0, 32'h0, 2'd0, 1'b1, 5'd7);
    tick();
    drive(1'b1, 32'h72, 32'h0, 32'h0, 2'd0, 1'b1, 5'd8);
    tick();
    chk("flush_pre_Count", 64'(CountOut), 64'd2);
    Flush = 1'b1;
    drive(1'b1, 32'h73, 32'h0, 32'h0, 2'd0, 1'b1, 5'd9);
    tick();
    Flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0);
    chk("flush_OutValid", 64'(OutValid), 64'd0);
    chk("flush_RegWriteOut", 64'(RegWriteOut), 64'd0);
    OutReady = 1'b1;
    tick();
    tick();

    // Asynchronous reset between edges while FULL.
    OutReady = 1'b0;
    drive(1'b1, 32'h81, 32'h1, 32'h2, 2'd1, 1'b1, 5'd4);
    tick();
    drive(1'b1, 32'h82, 32'h1, 32'h2, 2'd2, 1'b1, 5'd5);
    tick();
    chk("rst_pre_Count", 64'(CountOut), 64'd2);
    #2;
    Reset = 1'b1;
    #1;
    q.delete();
    check_zero("async_reset");
    drive(1'b1, 32'h90, 32'h0, 32'h0, 2'd0, 1'b1, 5'd6);
    tick();
    Reset = 1'b0;
    OutReady = 1'b1;
    tick();
    chk("post_reset_OutValid", 64'(OutValid), 64'd1);
    chk("post_reset_ALU", 64'(ALUResultOut), 64'h90);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0);
    tick();

    // Random traffic; payload held while the stage is not ready.
    held = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!held) begin
        drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)));
      end
      OutReady = 1'($urandom_range(0, 2) != 0);
      Flush = ($urandom_range(0, 29) == 0);
      held = InValid && (q.size() >= 2);
      tick();
      Flush = 1'b0;
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 5'd0);
    OutReady = 1'b1;
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
